// File: rtl/acos_unit_if.sv
// Start/done handshake bundle for acos_unit: master issues requests, slave (the unit) returns results.
interface acos_unit_if;
  logic        start;
  logic [15:0] cSig;
  logic        busy;
  logic        done;
  logic [15:0] angle;
  logic        rangeErr;

  modport master (output start, cSig, input busy, done, angle, rangeErr);
  modport slave  (input start, cSig, output busy, done, angle, rangeErr);
endinterface

// File: rtl/acos_unit.sv
// Iterative acos, Q5.11 in/out: sin = sqrt(1-c^2) by restoring root, then 12-step CORDIC vectoring.
// start->done is 26 cycles, start ignored while busy; ACOS_ROUND_EN rounds the Q.13 angle instead of truncating.
module acos_unit (
  input logic       clk,
  input logic       rst,
  acos_unit_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SQUARE, S_SQRT, S_CORDIC, S_DONE} state_t;

  state_t r_state, w_state_nx;
  logic [3:0]          r_cnt;
  logic signed [12:0]  r_c;
  logic                r_err_lat;
  logic [23:0]         r_rad;
  logic [13:0]         r_rem;
  logic [11:0]         r_root;
  logic signed [17:0]  r_x, r_y;
  logic signed [18:0]  r_z;
  logic                r_busy, r_done, r_err;
  logic [15:0]         r_angle;

  logic signed [15:0]  w_cin;
  logic signed [12:0]  w_c_clamped;
  logic                w_oor;
  logic signed [25:0]  w_c_wide, w_csq;
  logic [22:0]         w_r23;
  logic [15:0]         w_rem_sh, w_trial, w_rem_nx;
  logic [11:0]         w_root_nx;
  logic signed [17:0]  w_xs, w_ys;
  logic signed [18:0]  w_atan, w_zr;
  logic [15:0]         w_angle;

  function automatic logic signed [18:0] atan_q13(input logic [3:0] i);
    case (i)
      4'd0:    atan_q13 = 19'sd6434;
      4'd1:    atan_q13 = 19'sd3798;
      4'd2:    atan_q13 = 19'sd2007;
      4'd3:    atan_q13 = 19'sd1019;
      4'd4:    atan_q13 = 19'sd511;
      4'd5:    atan_q13 = 19'sd256;
      4'd6:    atan_q13 = 19'sd128;
      4'd7:    atan_q13 = 19'sd64;
      4'd8:    atan_q13 = 19'sd32;
      4'd9:    atan_q13 = 19'sd16;
      4'd10:   atan_q13 = 19'sd8;
      4'd11:   atan_q13 = 19'sd4;
      default: atan_q13 = 19'sd0;
    endcase
  endfunction

  always_comb begin
    w_cin       = bus.cSig;
    w_oor       = 1'b0;
    w_c_clamped = w_cin[12:0];
    if (w_cin > 16'sd2048) begin
      w_c_clamped = 13'sd2048;
      w_oor       = 1'b1;
    end else if (w_cin < -16'sd2048) begin
      w_c_clamped = -13'sd2048;
      w_oor       = 1'b1;
    end
  end

  assign w_c_wide = 26'(r_c);
  assign w_csq    = w_c_wide * w_c_wide;
  assign w_r23    = 23'd4194304 - 23'(w_csq);

  // One restoring root step: bring down two radicand bits, try (root<<2)|1.
  always_comb begin
    w_rem_sh  = {r_rem, r_rad[23:22]};
    w_trial   = {2'b00, r_root, 2'b01};
    w_rem_nx  = w_rem_sh;
    w_root_nx = {r_root[10:0], 1'b0};
    if (w_rem_sh >= w_trial) begin
      w_rem_nx  = w_rem_sh - w_trial;
      w_root_nx = {r_root[10:0], 1'b1};
    end
  end

  assign w_xs   = r_x >>> r_cnt;
  assign w_ys   = r_y >>> r_cnt;
  assign w_atan = atan_q13(r_cnt);

`ifdef ACOS_ROUND_EN
  assign w_zr = r_z + 19'sd2;
`else
  assign w_zr = r_z;
`endif
  assign w_angle = w_zr[18] ? 16'd0 : 16'(w_zr >>> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nx = S_SQUARE;
      S_SQUARE: w_state_nx = S_SQRT;
      S_SQRT:   if (r_cnt == 4'd11) w_state_nx = S_CORDIC;
      S_CORDIC: if (r_cnt == 4'd11) w_state_nx = S_DONE;
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_c <= '0; r_err_lat <= 1'b0; r_rad <= '0; r_rem <= '0; r_root <= '0;
      r_x <= '0; r_y <= '0; r_z <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0; r_angle <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_c       <= w_c_clamped;
          r_err_lat <= w_oor;
          r_busy    <= 1'b1;
        end
        S_SQUARE: begin
          r_rad  <= {1'b0, w_r23};
          r_rem  <= '0;
          r_root <= '0;
          r_cnt  <= '0;
        end
        S_SQRT: begin
          r_rem  <= 14'(w_rem_nx);
          r_root <= w_root_nx;
          r_rad  <= {r_rad[21:0], 2'b00};
          r_cnt  <= r_cnt + 4'd1;
          // Last root bit lands this edge, so CORDIC is seeded from the next-root value.
          if (r_cnt == 4'd11) begin
            r_cnt <= '0;
            if (!r_c[12]) begin
              r_x <= 18'(r_c);
              r_y <= $signed({6'b0, w_root_nx});
              r_z <= '0;
            end else begin
              r_x <= $signed({6'b0, w_root_nx});
              r_y <= -18'(r_c);
              r_z <= 19'sd12868;
            end
          end
        end
        S_CORDIC: begin
          if (!r_y[17]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          r_cnt <= r_cnt + 4'd1;
        end
        S_DONE: begin
          r_angle <= w_angle;
          r_err   <= r_err_lat;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.angle    = r_angle;
  assign bus.rangeErr = r_err;
endmodule

// File: tb/tb_acos_unit.sv
// Directed bench for acos_unit with a scoreboard of expected angles from a real-valued acos model.
module tb_acos_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acos_unit_if bus ();
  acos_unit dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ACOS_ROUND_EN
  localparam int TOL = 2;
`else
  localparam int TOL = 3;
`endif

  typedef struct {
    logic [15:0] c;
    int          ang;
    logic        err;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic sb_t model(input logic [15:0] c);
    sb_t e;
    int  v;
    real rv;
    v     = int'($signed(c));
    e.c   = c;
    e.err = (v > 2048) || (v < -2048);
    if (v > 2048)  v = 2048;
    if (v < -2048) v = -2048;
    rv    = $acos(real'(v) / 2048.0);
    e.ang = $rtoi(rv * 2048.0 + 0.5);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    n_tests++;
    assert ((obs - exp) <= TOL && (exp - obs) <= TOL) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, TOL);
    end
  endtask

  task automatic issue(input logic [15:0] c);
    @(negedge clk);
    bus.cSig  = c;
    bus.start = 1'b1;
    sb_q.push_back(model(c));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.cSig  = 16'h5A5A;
  endtask

  // Waits (bounded) for done, checks latency and the oldest scoreboard entry.
  task automatic collect(input string tag, input int exp_lat);
    int  cyc;
    sb_t e;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    if (bus.done === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_near({tag, "_angle"}, int'(bus.angle), e.ang);
      check({tag, "_err"}, 32'(bus.rangeErr), 32'(e.err));
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.cSig  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_done",  32'(bus.done),     32'd0);
    check("rst_angle", 32'(bus.angle),    32'd0);
    check("rst_err",   32'(bus.rangeErr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h0800); check("acc_busy", 32'(bus.busy), 32'd1); collect("one", 26);
    issue(16'h0000); collect("zero", 26);
    issue(16'hF800); collect("neg_one", 26);
    issue(16'h0400); collect("half", 26);
    issue(16'hFC00); collect("neg_half", 26);
    issue(16'h0C00); collect("over", 26);
    issue(16'h0400); collect("after_over", 26);

    // Second start during the operation must be ignored.
    issue(16'h0400);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.cSig  = 16'h0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    collect("ign", 16);
    count_done(40, nd);
    check("ign_extra_done", 32'(nd), 32'd0);
    check("ign_idle", 32'(bus.busy), 32'd0);

    // Clamped negative gives a nonzero angle and rangeErr=1 before the reset test.
    issue(16'h8000); collect("clamp_neg", 26);

    issue(16'hFC00);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    check("mid_rst_done",  32'(bus.done),     32'd0);
    check("mid_rst_angle", 32'(bus.angle),    32'd0);
    check("mid_rst_err",   32'(bus.rangeErr), 32'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    count_done(40, nd);
    check("mid_rst_no_done", 32'(nd), 32'd0);
    issue(16'h0000); collect("post_rst", 26);

    // Start held high: the second operation is accepted the cycle after done.
    @(negedge clk);
    bus.cSig  = 16'h0400;
    bus.start = 1'b1;
    sb_q.push_back(model(16'h0400));
    @(posedge clk);
    #1;
    bus.cSig = 16'hFC00;
    sb_q.push_back(model(16'hFC00));
    collect("b2b_first", 26);
    check("b2b_reaccept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.cSig  = 16'h1234;
    collect("b2b_second", 26);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
